// File: rtl/mc_cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM:
// opcode/funct values, state codes, instruction classes and datapath
// select encodings.
package mc_cpu_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_ALU_WB   = 4'd7,
    S_IMM_EX   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_ILLEGAL  = 4'd15
  } state_e;

  // Instruction class as seen by DECODE
  typedef enum logic [2:0] {
    CL_MEM, CL_RTYPE, CL_IMM, CL_BNE, CL_J, CL_JAL, CL_BAD
  } iclass_e;

  // alu_op
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_XORI = 3'd4;

  // pc_src
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REGA   = 2'd3;

  // alusrcb
  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  // regdst
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  // memtoreg
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

endpackage

// File: rtl/mc_cpu_ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class, store flag,
// R-type funct legality/JR detect and the ALU operation for EX states.
module mc_ctrl_decode
  import mc_cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output iclass_e         cls,
  output logic            is_sw,
  output logic            r_jr,
  output logic            r_ok,
  output logic [2:0]      alu_op
);

  // Classify opcode; funct only matters for R-type
  always_comb begin
    cls    = CL_BAD;
    is_sw  = 1'b0;
    r_jr   = 1'b0;
    r_ok   = 1'b0;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LW:   cls = CL_MEM;
      OP_SW:   begin cls = CL_MEM; is_sw = 1'b1; end
      OP_RTYPE: begin
        cls = CL_RTYPE;
        case (funct)
          F_ADD:   begin r_ok = 1'b1; alu_op = ALU_ADD; end
          F_SUB:   begin r_ok = 1'b1; alu_op = ALU_SUB; end
          F_SLT:   begin r_ok = 1'b1; alu_op = ALU_SLT; end
          F_JR:    r_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin cls = CL_IMM; alu_op = ALU_ADD;  end
      OP_XORI: begin cls = CL_IMM; alu_op = ALU_XORI; end
      OP_BNE:  cls = CL_BNE;
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      default: cls = CL_BAD;
    endcase
  end

endmodule

// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle control FSM for the shared-memory MIPS-subset datapath.
// Moore outputs decoded from the state register (BRANCH pc_we also uses
// zero; FETCH ir_we/pc_we wait for mem_ready). Every output is forced to
// 0 while reset_n is low so a reset mid-access drops requests at once.
// Optional: MC_CTRL_PERF_EN adds cyc_cnt/instr_cnt performance counters.
module mc_cpu_ctrl
  import mc_cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_re,
  output logic            mem_we,
  output logic            iord,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            reg_we,
  output logic [1:0]      regdst,
  output logic [1:0]      memtoreg,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [2:0]      alu_op,
  output logic            illegal,
  output logic [ST_W-1:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  state_e     state_q;
  logic       rdst_q;     // 1: writeback targets rd (R-type), 0: rt (imm)
  logic       illegal_q;

  iclass_e    cls;
  logic       is_sw, r_jr, r_ok;
  logic [2:0] dec_alu;

  mc_ctrl_decode #(.OP_W(OP_W)) u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls),
    .is_sw  (is_sw),
    .r_jr   (r_jr),
    .r_ok   (r_ok),
    .alu_op (dec_alu)
  );

  // State register, writeback-destination flag and sticky illegal flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      rdst_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (cls)
            CL_MEM:   state_q <= S_MEMADR;
            CL_RTYPE: state_q <= S_RTYPE_EX;
            CL_IMM:   state_q <= S_IMM_EX;
            CL_BNE:   state_q <= S_BRANCH;
            CL_J:     state_q <= S_JUMP;
            CL_JAL:   state_q <= S_JAL;
            default: begin
              state_q   <= S_ILLEGAL;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state_q <= is_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
        S_RTYPE_EX: begin
          rdst_q <= 1'b1;
          if (r_jr) state_q <= S_FETCH;
          else if (!r_ok) begin
            state_q   <= S_ILLEGAL;
            illegal_q <= 1'b1;
          end else state_q <= S_ALU_WB;
        end
        S_ALU_WB: state_q <= S_FETCH;
        S_IMM_EX: begin
          rdst_q  <= 1'b0;
          state_q <= S_ALU_WB;
        end
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_JAL:    state_q <= S_FETCH;
        S_ILLEGAL: begin
          state_q   <= S_ILLEGAL;
          illegal_q <= 1'b1;
        end
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state, gated off in reset
  always_comb begin
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_ALU;
    reg_we   = 1'b0;
    regdst   = RD_RT;
    memtoreg = M2R_ALU;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    alu_op   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_re  = 1'b1;
        alusrcb = SRCB_4;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin alusrca = 1'b1; alusrcb = SRCB_IMM; end
      S_MEMRD:  begin mem_re = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin reg_we = 1'b1; memtoreg = M2R_MDR; end
      S_MEMWR:  begin mem_we = 1'b1; iord = 1'b1; end
      S_RTYPE_EX: begin
        alusrca = 1'b1;
        alu_op  = dec_alu;
        if (r_jr) begin pc_we = 1'b1; pc_src = PC_REGA; end
      end
      S_ALU_WB: begin
        reg_we = 1'b1;
        regdst = rdst_q ? RD_RD : RD_RT;
      end
      S_IMM_EX: begin alusrca = 1'b1; alusrcb = SRCB_IMM; alu_op = dec_alu; end
      S_BRANCH: begin
        alusrca = 1'b1;
        alu_op  = ALU_SUB;
        pc_src  = PC_ALUOUT;
        pc_we   = !zero;
      end
      S_JUMP:   begin pc_we = 1'b1; pc_src = PC_JUMP; end
      S_JAL: begin
        reg_we   = 1'b1;
        regdst   = RD_RA;
        memtoreg = M2R_PC;
        pc_we    = 1'b1;
        pc_src   = PC_JUMP;
      end
      default: ;
    endcase
    if (!reset_n) begin
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      iord     = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = PC_ALU;
      reg_we   = 1'b0;
      regdst   = RD_RT;
      memtoreg = M2R_ALU;
      alusrca  = 1'b0;
      alusrcb  = SRCB_B;
      alu_op   = ALU_ADD;
    end
  end

  assign illegal = illegal_q;
  assign state   = ST_W'(state_q);

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q, instr_q;

  // Cycle and retired-fetch counters, wrapping modulo 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_ILLEGAL) cyc_q <= cyc_q + 32'd1;
      if (state_q == S_FETCH && mem_ready) instr_q <= instr_q + 32'd1;
    end
  end

  assign cyc_cnt   = cyc_q;
  assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// Self-checking bench for mc_cpu_ctrl: directed scenarios plus a random
// instruction stream. Expected per-cycle behaviour comes from a state-path
// table per instruction and a per-phase output table.
module tb_mc_cpu_ctrl;

  localparam logic [5:0] RT = 6'h00, J = 6'h02, JAL = 6'h03, BNE = 6'h05,
                         ADDI = 6'h08, XORI = 6'h0E, LW = 6'h23, SW = 6'h2B;
  localparam logic [5:0] FJR = 6'h08, FADD = 6'h20, FSUB = 6'h22, FSLT = 6'h2A;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_re, mem_we, iord, ir_we, pc_we, reg_we, alusrca, illegal;
  logic [1:0] pc_src, regdst, memtoreg, alusrcb;
  logic [2:0] alu_op;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int checks = 0, errors = 0;

  mc_cpu_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we),
    .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .alu_op(alu_op),
    .illegal(illegal), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [5:0]  obs_en;
  logic [12:0] obs_sel;
  assign obs_en  = {mem_re, mem_we, ir_we, pc_we, reg_we, illegal};
  assign obs_sel = {iord, pc_src, regdst, memtoreg, alusrca, alusrcb, alu_op};

  typedef struct packed {
    logic [5:0]  en;
    logic [12:0] sel;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected controls for one cycle spent in phase st
  function automatic exp_t expect_of(input int st, input bit rdy, input bit z,
                                     input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    logic mre = 0, mwe = 0, irw = 0, pcw = 0, rgw = 0, ill = 0, io = 0, asa = 0;
    logic [1:0] pcs = 0, rdst = 0, m2r = 0, asb = 0;
    logic [2:0] aop = 0;
    case (st)
      0:  begin mre = 1; asb = 1; irw = rdy; pcw = rdy; end
      1:  asb = 3;
      2:  begin asa = 1; asb = 2; end
      3:  begin mre = 1; io = 1; end
      4:  begin rgw = 1; m2r = 1; end
      5:  begin mwe = 1; io = 1; end
      6:  begin
        asa = 1;
        if (fn == FSUB) aop = 1;
        else if (fn == FSLT) aop = 3;
        if (fn == FJR) begin pcw = 1; pcs = 3; end
      end
      7:  begin rgw = 1; rdst = (op == RT) ? 2'd1 : 2'd0; end
      8:  begin asa = 1; asb = 2; aop = (op == XORI) ? 3'd4 : 3'd0; end
      9:  begin asa = 1; aop = 1; pcs = 1; pcw = !z; end
      10: begin pcw = 1; pcs = 2; end
      11: begin rgw = 1; rdst = 2; m2r = 2; pcw = 1; pcs = 2; end
      15: ill = 1;
      default: ;
    endcase
    e.en  = {mre, mwe, irw, pcw, rgw, ill};
    e.sel = {io, pcs, rdst, m2r, asa, asb, aop};
    return e;
  endfunction

  // One clock: drive, check mid-cycle, advance to just past the next edge
  task automatic cycle(input int st, input bit rdy, input logic [5:0] op,
                       input logic [5:0] fn, input bit z);
    exp_t e;
    opcode = op; funct = fn; zero = z; mem_ready = rdy;
    @(negedge clk);
    e = expect_of(st, rdy, z, op, fn);
    chk($sformatf("state@%0d", st), 32'(state), 32'(st));
    chk($sformatf("en@%0d", st), 32'(obs_en), 32'(e.en));
    if (!(st == 0 && !rdy))
      chk($sformatf("sel@%0d", st), 32'(obs_sel), 32'(e.sel));
    @(posedge clk); #1;
  endtask

  // Whole instruction: path of phases from the instruction's rules,
  // with random wait cycles on memory phases when stall_en is set
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input bit stall_en);
    int path[$];
    path = '{0, 1};
    case (op)
      LW:   path = '{0, 1, 2, 3, 4};
      SW:   path = '{0, 1, 2, 5};
      RT:   path = (fn == FJR) ? '{0, 1, 6} : '{0, 1, 6, 7};
      ADDI, XORI: path = '{0, 1, 8, 7};
      BNE:  path = '{0, 1, 9};
      J:    path = '{0, 1, 10};
      JAL:  path = '{0, 1, 11};
      default: ;
    endcase
    foreach (path[i]) begin
      if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
        int n = stall_en ? int'($urandom_range(0, 2)) : 0;
        repeat (n) cycle(path[i], 1'b0, op, fn, z);
        cycle(path[i], 1'b1, op, fn, z);
      end else begin
        cycle(path[i], 1'($urandom_range(0, 1)), op, fn, z);
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(obs_en), 32'd0);
    chk("rst_sel", 32'(obs_sel), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held: FETCH encoding, everything quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_state", 32'(state), 32'd0);
    chk("rst_hold_en", 32'(obs_en), 32'd0);
    chk("rst_hold_sel", 32'(obs_sel), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // FETCH stalled 3 cycles, then LW with single-cycle accesses
    repeat (3) cycle(0, 1'b0, LW, 6'h00, 1'b0);
    cycle(0, 1'b1, LW, 6'h00, 1'b0);
    cycle(1, 1'b1, LW, 6'h00, 1'b0);
    cycle(2, 1'b1, LW, 6'h00, 1'b0);
    cycle(3, 1'b1, LW, 6'h00, 1'b0);
    cycle(4, 1'b1, LW, 6'h00, 1'b0);

    // Branch taken/not taken, JAL, JR, register and immediate ops
    run_instr(BNE, 6'h11, 1'b1, 1'b0);
    run_instr(BNE, 6'h11, 1'b0, 1'b0);
    run_instr(JAL, 6'h00, 1'b0, 1'b0);
    run_instr(RT, FJR, 1'b0, 1'b0);
    run_instr(RT, FSUB, 1'b0, 1'b0);
    run_instr(XORI, 6'h3F, 1'b0, 1'b0);
    run_instr(SW, 6'h00, 1'b0, 1'b1);

    // Random legal instruction stream with random memory wait states
    for (int k = 0; k < 150; k++) begin
      logic [5:0] op, fn;
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 10))
        0: op = LW;    1: op = SW;
        2: begin op = RT; fn = FADD; end
        3: begin op = RT; fn = FSUB; end
        4: begin op = RT; fn = FSLT; end
        5: begin op = RT; fn = FJR;  end
        6: op = ADDI;  7: op = XORI;
        8: op = BNE;   9: op = J;
        default: op = JAL;
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset asserted while MEMWR is waiting drops mem_we immediately
    cycle(0, 1'b1, SW, 6'h00, 1'b0);
    cycle(1, 1'b1, SW, 6'h00, 1'b0);
    cycle(2, 1'b1, SW, 6'h00, 1'b0);
    cycle(5, 1'b0, SW, 6'h00, 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("memwr_held_we", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("memwr_rst_we", 32'(mem_we), 32'd0);
    chk("memwr_rst_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycle(0, 1'b0, LW, 6'h00, 1'b0);
    run_instr(ADDI, 6'h00, 1'b0, 1'b0);

    // Back-to-back ADDIs at nominal CPI
    do_reset();
    repeat (4) run_instr(ADDI, 6'h05, 1'b0, 1'b0);
`ifdef MC_CTRL_PERF_EN
    chk("perf_instr", instr_cnt, 32'd4);
    chk("perf_cyc", cyc_cnt, 32'd16);
`endif

    // Unknown R-type funct traps
    do_reset();
    cycle(0, 1'b1, RT, 6'h3F, 1'b0);
    cycle(1, 1'b1, RT, 6'h3F, 1'b0);
    cycle(6, 1'b1, RT, 6'h3F, 1'b0);
    repeat (3) cycle(15, 1'($urandom_range(0, 1)), RT, 6'h3F, 1'b0);

    // Unsupported opcode traps and stays trapped
    do_reset();
    cycle(0, 1'b1, 6'h3F, 6'h00, 1'b0);
    cycle(1, 1'b1, 6'h3F, 6'h00, 1'b0);
    for (int k = 0; k < 10; k++)
      cycle(15, 1'($urandom_range(0, 1)), 6'h3F, 6'h00, 1'($urandom_range(0, 1)));
`ifdef MC_CTRL_PERF_EN
    chk("perf_cyc_frozen", cyc_cnt, 32'd2);
    chk("perf_instr_trap", instr_cnt, 32'd1);
`endif
    do_reset();
    cycle(0, 1'b0, LW, 6'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
